// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with a single-line refill engine.
// Define ICACHE_LRU_EN for per-set LRU replacement (WAYS=2); otherwise a global round-robin bit picks the victim.
module icache_sa #(
    parameter int INDEX_BITS     = 4,
    parameter int LINE_WORDS_LOG = 2,
    parameter int WAYS           = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        stall,
    input  logic        fet_icache_enable,
    input  logic [31:0] fet_pc,
    output logic        icache_ready,
    output logic [31:0] icache_inst,
    output logic        icache_mem_req,
    output logic [31:0] icache_mem_addr,
    input  logic        mem_inst_ready,
    input  logic [31:0] mem_inst,
    input  logic        invalidate
);

    localparam int SETS    = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << LINE_WORDS_LOG;
    localparam int IDX_LSB = LINE_WORDS_LOG + 2;
    localparam int TAG_LSB = IDX_LSB + INDEX_BITS;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [31:0] LINE_MASK = 32'((1 << IDX_LSB) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_INSTALL
    } state_t;

    state_t                    state_q, state_d;
    logic [LINE_WORDS_LOG-1:0] cnt_q, cnt_d;
    logic [31:0]               addr_q, addr_d;
    logic                      discard_q, discard_d;
    logic [SETS-1:0]           valid_q [WAYS];
    logic [SETS-1:0]           valid_d [WAYS];

    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    logic [31:0]               data_q [WAYS][SETS][WORDS];
    logic [31:0]               buf_q  [WORDS];

`ifdef ICACHE_LRU_EN
    logic [SETS-1:0]           lru_q, lru_d;
`else
    logic                      rr_q, rr_d;
`endif

    logic [1:0][31:0]             look_addr;
    logic [1:0][INDEX_BITS-1:0]   look_idx;
    logic [1:0][TAG_W-1:0]        look_tag;
    logic [1:0][LINE_WORDS_LOG-1:0] look_word;
    logic [1:0]                   look_hit;
    logic [1:0]                   look_way;
    logic [1:0][15:0]             look_half;
    logic [31:0]                  look_data;

    logic                  lo_comp;
    logic                  hit_ok;
    logic                  fetch_go;
    logic [31:0]           miss_base;
    logic                  install;
    logic                  victim;
    logic                  policy_way;
    logic [INDEX_BITS-1:0] inst_idx;
    logic [TAG_W-1:0]      inst_tag;

    // Lookup port 0 is the fetch halfword, port 1 the following halfword (upper half of a 32-bit op).
    always_comb begin
        look_addr[0] = fet_pc;
        look_addr[1] = fet_pc + 32'd2;
        look_idx     = '0;
        look_tag     = '0;
        look_word    = '0;
        look_hit     = '0;
        look_way     = '0;
        look_half    = '0;
        look_data    = '0;
        for (int p = 0; p < 2; p++) begin
            look_idx[p]  = look_addr[p][TAG_LSB-1:IDX_LSB];
            look_tag[p]  = look_addr[p][31:TAG_LSB];
            look_word[p] = look_addr[p][IDX_LSB-1:2];
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[w][look_idx[p]] && (tag_q[w][look_idx[p]] == look_tag[p])) begin
                    look_hit[p]  = 1'b1;
                    look_way[p]  = w[0];
                    look_data    = data_q[w][look_idx[p]][look_word[p]];
                    look_half[p] = look_addr[p][1] ? look_data[31:16] : look_data[15:0];
                end
            end
        end
    end

    always_comb begin
        lo_comp   = (look_half[0][1:0] != 2'b11);
        hit_ok    = look_hit[0] && (lo_comp || look_hit[1]);
        fetch_go  = fet_icache_enable && !stall && !flush && (state_q == S_IDLE);
        // Refill whichever line is missing; the low halfword's line always goes first.
        miss_base = (look_hit[0] ? look_addr[1] : look_addr[0]) & ~LINE_MASK;
        install   = rdy && (state_q == S_INSTALL);
        inst_idx  = addr_q[TAG_LSB-1:IDX_LSB];
        inst_tag  = addr_q[31:TAG_LSB];
    end

`ifdef ICACHE_LRU_EN
    assign policy_way = lru_q[inst_idx];
`else
    assign policy_way = rr_q;
    logic unused_way;
    assign unused_way = ^look_way;
`endif

    always_comb begin
        victim = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][inst_idx]) begin
                victim = 1'b0;
            end else if (!valid_q[WAYS-1][inst_idx]) begin
                victim = 1'b1;
            end else begin
                victim = policy_way;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            discard_q <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
`ifdef ICACHE_LRU_EN
            lru_q     <= '0;
`else
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
`ifdef ICACHE_LRU_EN
            lru_q     <= lru_d;
`else
            rr_q      <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_go && !hit_ok) begin
                        state_d   = S_REFILL;
                        addr_d    = miss_base;
                        cnt_d     = '0;
                        discard_d = 1'b0;
                    end
                end
                S_REFILL: begin
                    if (invalidate) begin
                        discard_d = 1'b1;
                    end
                    if (mem_inst_ready) begin
                        cnt_d = cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_d = S_INSTALL;
                        end
                    end
                end
                S_INSTALL: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            valid_d[w] = valid_q[w];
            if (install && (victim == w[0])) begin
                valid_d[w][inst_idx] = !discard_q;
            end
            if (rdy && invalidate) begin
                valid_d[w] = '0;
            end
        end
    end

`ifdef ICACHE_LRU_EN
    always_comb begin
        lru_d = lru_q;
        if (rdy && icache_ready) begin
            lru_d[look_idx[0]] = !look_way[0];
            if (!lo_comp) begin
                lru_d[look_idx[1]] = !look_way[1];
            end
        end
        if (install) begin
            lru_d[inst_idx] = !victim;
        end
    end
`else
    always_comb begin
        rr_d = rr_q;
        if (install) begin
            rr_d = !rr_q;
        end
    end
`endif

    // Line storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (rdy && (state_q == S_REFILL) && mem_inst_ready) begin
            buf_q[cnt_q] <= mem_inst;
        end
        if (install) begin
            for (int w = 0; w < WAYS; w++) begin
                if (victim == w[0]) begin
                    tag_q[w][inst_idx] <= inst_tag;
                    for (int k = 0; k < WORDS; k++) begin
                        data_q[w][inst_idx][k] <= buf_q[k];
                    end
                end
            end
        end
    end

    always_comb begin
        icache_ready    = fetch_go && hit_ok;
        icache_inst     = '0;
        if (icache_ready) begin
            icache_inst = lo_comp ? {16'h0000, look_half[0]} : {look_half[1], look_half[0]};
        end
        icache_mem_req  = (state_q == S_REFILL);
        icache_mem_addr = icache_mem_req ? addr_q : '0;
    end

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: a memory responder serves refills and fetched instructions are compared against a memory model.
module tb_icache_sa;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        fet_icache_enable = 1'b0;
    logic [31:0] fet_pc = '0;
    logic        invalidate = 1'b0;
    logic        mem_inst_ready;
    logic [31:0] mem_inst;
    logic        icache_ready;
    logic [31:0] icache_inst;
    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;

    int          checks = 0;
    int          errors = 0;
    int          refills = 0;
    logic [31:0] last_addr = '0;
    int          mem_gap = 0;
    bit          spurious = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_sa #(
        .INDEX_BITS    (4),
        .LINE_WORDS_LOG(2),
        .WAYS          (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .flush            (flush),
        .stall            (stall),
        .fet_icache_enable(fet_icache_enable),
        .fet_pc           (fet_pc),
        .icache_ready     (icache_ready),
        .icache_inst      (icache_inst),
        .icache_mem_req   (icache_mem_req),
        .icache_mem_addr  (icache_mem_addr),
        .mem_inst_ready   (mem_inst_ready),
        .mem_inst         (mem_inst),
        .invalidate       (invalidate)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        case (w)
            32'h0000_0004: return 32'h4501_0001;
            32'h0000_000C: return 32'h0513_2222;
            32'h0000_0010: return 32'hABCD_0093;
            default:       return {w[15:2] ^ 14'h1555, 2'b10, w[17:4] ^ 14'h0ACE, 2'b00};
        endcase
    endfunction

    function automatic logic [15:0] mhalf(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [15:0] lo;
        lo = mhalf(pc);
        if (lo[1:0] == 2'b11) return {mhalf(pc + 32'd2), lo};
        return {16'h0000, lo};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Refill responder: one word every (mem_gap+1) cycles while the request is up.
    initial begin
        int sent;
        int gctr;
        bit busy;
        mem_inst_ready = 1'b0;
        mem_inst = '0;
        sent = 0;
        gctr = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (icache_mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    refills++;
                    last_addr = icache_mem_addr;
                    sent = 0;
                    gctr = 0;
                end
                if (sent < WORDS && gctr == mem_gap) begin
                    mem_inst_ready = 1'b1;
                    mem_inst = mem_word(last_addr + 32'(4 * sent));
                    sent++;
                    gctr = 0;
                end else begin
                    mem_inst_ready = 1'b0;
                    gctr++;
                end
            end else begin
                busy = 1'b0;
                mem_inst_ready = spurious;
                mem_inst = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input string tag, output int lat);
        logic [31:0] e;
        exp_q.push_back(exp_inst(pc));
        fet_pc = pc;
        fet_icache_enable = 1'b1;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (icache_ready) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check_val({tag, "_rdy"}, {31'b0, icache_ready}, 32'd1);
        if (lat >= 0) check_val({tag, "_inst"}, icache_inst, e);
        @(negedge clk);
        fet_icache_enable = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input string tag, input int exp_lat, input int exp_new);
        int r0;
        int lat;
        r0 = refills;
        fetch(pc, tag, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_refills"}, 32'(refills - r0), 32'(exp_new));
    endtask

    task automatic wait_refill_done(input string tag);
        int n;
        n = 0;
        while (icache_mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done"}, {31'b0, icache_mem_req}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        @(negedge clk);
        #1;
        check_val("rst_ready", {31'b0, icache_ready}, 32'd0);
        check_val("rst_inst", icache_inst, 32'd0);
        check_val("rst_req", {31'b0, icache_mem_req}, 32'd0);
        check_val("rst_addr", icache_mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_fetch(32'h0000_0000, "cold", 6, 1);
        check_val("cold_addr", last_addr, 32'h0000_0000);
        do_fetch(32'h0000_0006, "comp", 0, 0);
        do_fetch(32'h0000_000E, "strad", 6, 1);
        check_val("strad_addr", last_addr, 32'h0000_0010);
        do_fetch(32'h0000_0010, "w32", 0, 0);
        do_fetch(32'h0000_001E, "cedge", 0, 0);

        fet_pc = 32'h0000_0006;
        fet_icache_enable = 1'b1;
        stall = 1'b1;
        #1 check_val("stall_hit", {31'b0, icache_ready}, 32'd0);
        stall = 1'b0;
        flush = 1'b1;
        #1 check_val("flush_hit", {31'b0, icache_ready}, 32'd0);
        flush = 1'b0;
        #1 check_val("plain_hit", {31'b0, icache_ready}, 32'd1);
        check_val("plain_inst", icache_inst, 32'h0000_4501);
        @(negedge clk);
        fet_pc = 32'h0000_0700;
        stall = 1'b1;
        @(negedge clk);
        check_val("stall_noreq", {31'b0, icache_mem_req}, 32'd0);
        stall = 1'b0;
        fet_icache_enable = 1'b0;
        @(negedge clk);

        do_fetch(32'h0000_0030, "set3_a", 6, 1);
        do_fetch(32'h0000_0130, "set3_b", 6, 1);
        do_fetch(32'h0000_0030, "set3_ahit", 0, 0);
        do_fetch(32'h0000_0230, "set3_c", 6, 1);
`ifdef ICACHE_LRU_EN
        do_fetch(32'h0000_0030, "lru_akeep", 0, 0);
        do_fetch(32'h0000_0130, "lru_bgone", 6, 1);
`else
        do_fetch(32'h0000_0130, "rr_bkeep", 0, 0);
        do_fetch(32'h0000_0030, "rr_agone", 6, 1);
`endif

        r0 = refills;
        fet_pc = 32'h0000_0400;
        fet_icache_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check_val("fl_rdy", {31'b0, icache_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        fet_icache_enable = 1'b0;
        wait_refill_done("fl");
        check_val("fl_refills", 32'(refills - r0), 32'd1);
        do_fetch(32'h0000_0400, "fl_refetch", 0, 0);

        fet_pc = 32'h0000_0500;
        fet_icache_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        fet_icache_enable = 1'b0;
        wait_refill_done("inv");
        do_fetch(32'h0000_0500, "inv_refetch", 6, 1);
        do_fetch(32'h0000_0000, "inv_line0", 6, 1);

        fet_pc = 32'h0000_0600;
        fet_icache_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_val("rstmid_req", {31'b0, icache_mem_req}, 32'd0);
        check_val("rstmid_addr", icache_mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fet_icache_enable = 1'b0;
        @(negedge clk);
        do_fetch(32'h0000_0500, "rst_refetch", 6, 1);

        fet_pc = 32'h0000_0800;
        fet_icache_enable = 1'b1;
        rdy = 1'b0;
        @(negedge clk);
        check_val("rdy_noreq", {31'b0, icache_mem_req}, 32'd0);
        rdy = 1'b1;
        fet_icache_enable = 1'b0;
        do_fetch(32'h0000_0800, "rdy_miss", 6, 1);

        mem_gap = 1;
        do_fetch(32'h0000_0900, "lat_n2", 10, 1);
        mem_gap = 0;

        spurious = 1'b1;
        repeat (2) @(negedge clk);
        do_fetch(32'h0000_0A00, "spur", 6, 1);
        spurious = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
